// File: rtl/sht10_crc_check.sv
// CRC-8 checker for SHT10 transactions: {cmd, MSB, LSB} are folded into the CRC one bit
// per clock, then the received checksum is compared against the bit-reversed result.
module sht10_crc_check #(
  parameter logic [7:0] POLY       = 8'h31,
  parameter int         DATA_BYTES = 3
) (
  input  logic       clock_i,
  input  logic       reset_i,
  input  logic       frame_start_i,
  input  logic [3:0] status_init_i,
  input  logic       byte_valid_i,
  input  logic [7:0] byte_data_i,
  output logic       byte_ready_o,
  output logic       crc_done_o,
  output logic       crc_ok_o,
  output logic [7:0] crc_calc_o,
  output logic       frame_error_o
);

  typedef enum logic [1:0] {IDLE, WAIT_BYTE, SHIFT, CHECK} state_t;

  localparam logic [1:0] LAST_CNT = DATA_BYTES[1:0];

  state_t     state_q;
  logic [7:0] crc_q;
  logic [7:0] crc_d;
  logic [7:0] crc_rev;
  logic [7:0] shift_q;
  logic [2:0] bit_cnt_q;
  logic [1:0] byte_cnt_q;
  logic       crc_done_q;
  logic       crc_ok_q;
  logic [7:0] crc_calc_q;
  logic       frame_error_q;
  logic       feedback;
  logic       handshake;

  function automatic logic [7:0] bitrev8(input logic [7:0] v);
    logic [7:0] r;
    for (int i = 0; i < 8; i++) r[i] = v[7-i];
    return r;
  endfunction

  always_comb begin
    feedback     = crc_q[7] ^ shift_q[7];
    crc_d        = {crc_q[6:0], 1'b0} ^ (feedback ? POLY : 8'h00);
    crc_rev      = bitrev8(crc_q);
    // frame_start wins over a same-cycle byte, so ready drops combinationally
    byte_ready_o = (state_q == WAIT_BYTE) && !frame_start_i;
    handshake    = byte_ready_o && byte_valid_i;
  end

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      state_q       <= IDLE;
      crc_q         <= 8'h00;
      shift_q       <= 8'h00;
      bit_cnt_q     <= 3'd0;
      byte_cnt_q    <= 2'd0;
      crc_done_q    <= 1'b0;
      crc_ok_q      <= 1'b0;
      crc_calc_q    <= 8'h00;
      frame_error_q <= 1'b0;
    end else begin
      crc_done_q    <= 1'b0;
      frame_error_q <= 1'b0;
      if (frame_start_i) begin
        frame_error_q <= (state_q == SHIFT) ||
                         ((state_q == WAIT_BYTE) && (byte_cnt_q != 2'd0));
        crc_q         <= {status_init_i[0], status_init_i[1],
                          status_init_i[2], status_init_i[3], 4'b0000};
        byte_cnt_q    <= 2'd0;
        crc_ok_q      <= 1'b0;
        crc_calc_q    <= 8'h00;
        state_q       <= WAIT_BYTE;
      end else begin
        case (state_q)
          IDLE: ;
          WAIT_BYTE: begin
            if (handshake) begin
              shift_q <= byte_data_i;
              if (byte_cnt_q == LAST_CNT) begin
                state_q <= CHECK;
              end else begin
                bit_cnt_q <= 3'd7;
                state_q   <= SHIFT;
              end
            end
          end
          SHIFT: begin
            crc_q     <= crc_d;
            shift_q   <= {shift_q[6:0], 1'b0};
            bit_cnt_q <= bit_cnt_q - 3'd1;
            if (bit_cnt_q == 3'd0) begin
              byte_cnt_q <= byte_cnt_q + 2'd1;
              state_q    <= WAIT_BYTE;
            end
          end
          CHECK: begin
            crc_calc_q <= crc_rev;
            crc_ok_q   <= (crc_rev == shift_q);
            crc_done_q <= 1'b1;
            state_q    <= IDLE;
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign crc_done_o    = crc_done_q;
  assign crc_ok_o      = crc_ok_q;
  assign crc_calc_o    = crc_calc_q;
  assign frame_error_o = frame_error_q;

endmodule
